imr_adc_sample_fifo: RTL and testbench

- Downstream stage of the dual-channel ADC7476A controller.
- Captures each completed A/B conversion pair when the controller flags data ready, and packs it into one 32-bit word.
- Buffers words in a FIFO so software can drain a continuous-conversion burst (up to 4096 samples) through AXI reads without losing samples between interrupts.
- Provides level, sticky overflow/underflow flags and a threshold interrupt.

---
 rtl/imr_adc_sample_fifo.sv | 132 +++++++++++++
 tb/tb_imr_adc_sample_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imr_adc_sample_fifo.sv
// imr_adc_sample_fifo: captures ADC7476A A/B conversion pairs on the rising
// edge of Sample_Ready, packs them with a 4-bit sequence tag and buffers them
// in a synchronous-read RAM FIFO with level, sticky error flags and an IRQ.
module imr_adc_sample_fifo #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          SysClk,
    input  logic          RST,
    input  logic          Enable,
    input  logic          Sample_Ready,
    input  logic [11:0]   Data_A,
    input  logic [11:0]   Data_B,
    input  logic          Flush,
    input  logic          Rd_En,
    output logic [31:0]   Rd_Data,
    output logic          Rd_Valid,
    output logic [AW:0]   Level,
    output logic          Empty,
    output logic          Full,
    input  logic [AW:0]   Threshold,
    input  logic          Flag_Clear,
    output logic          Overflow,
    output logic          Underflow,
    output logic          FIFO_IRQ
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [3:0]    seq_q, seq_d;
    logic          sr_q;
    logic [31:0]   rd_data_q;
    logic          rd_valid_q;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          wr_req, rd_ok, wr_ok, wr_en, rd_en, ovf_evt, udf_evt;
    logic [31:0]   wr_word;

    // Request decode, acceptance and next-state for pointers, level, tag, flags
    always_comb begin
        wr_req  = Enable & Sample_Ready & ~sr_q;
        rd_ok   = Rd_En & (level_q != '0);
        wr_ok   = wr_req & ((level_q != DEPTH_L) | rd_ok);
        wr_en   = wr_ok & ~Flush;
        rd_en   = rd_ok & ~Flush;
        ovf_evt = wr_req & ~wr_ok & ~Flush;
        udf_evt = Rd_En & (level_q == '0) & ~Flush;
        wr_word = {seq_q, Data_B, 4'b0000, Data_A};

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        seq_d   = seq_q;
        if (Flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            seq_d   = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + AW'(1);
                seq_d  = seq_q + 4'd1;
            end
            if (rd_en) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end

        // A new event in the same cycle as Flag_Clear keeps the flag set
        ovf_d = (ovf_q & ~Flag_Clear) | ovf_evt;
        udf_d = (udf_q & ~Flag_Clear) | udf_evt;
    end

    // Sample storage: no reset so it maps onto block RAM
    always_ff @(posedge SysClk) begin
        if (wr_en && !RST) begin
            mem_q[wptr_q] <= wr_word;
        end
    end

    // Control state, registered read port and sticky flags
    always_ff @(posedge SysClk) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            // Tracking the input during reset means a level already high at
            // release is seen as old, not as a fresh rising edge
            sr_q       <= Sample_Ready;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[rptr_q];
            end
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            sr_q       <= Sample_Ready;
        end
    end

    // Status outputs derived from the registered level
    always_comb begin
        Rd_Data   = rd_data_q;
        Rd_Valid  = rd_valid_q;
        Level     = level_q;
        Empty     = (level_q == '0);
        Full      = (level_q == DEPTH_L);
        Overflow  = ovf_q;
        Underflow = udf_q;
        FIFO_IRQ  = (Threshold != '0) && (level_q >= Threshold);
    end

endmodule

// File: tb/tb_imr_adc_sample_fifo.sv
// tb_imr_adc_sample_fifo: directed plus randomized stimulus for the sample
// FIFO, checked every cycle against a queue-based model of the FIFO rules.
module tb_imr_adc_sample_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          SysClk = 1'b0;
    logic          RST = 1'b1;
    logic          Enable = 1'b0;
    logic          Sample_Ready = 1'b0;
    logic [11:0]   Data_A = '0;
    logic [11:0]   Data_B = '0;
    logic          Flush = 1'b0;
    logic          Rd_En = 1'b0;
    logic [31:0]   Rd_Data;
    logic          Rd_Valid;
    logic [AW:0]   Level;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Threshold = '0;
    logic          Flag_Clear = 1'b0;
    logic          Overflow;
    logic          Underflow;
    logic          FIFO_IRQ;

    imr_adc_sample_fifo #(.DEPTH(DEPTH)) dut (
        .SysClk(SysClk), .RST(RST), .Enable(Enable), .Sample_Ready(Sample_Ready),
        .Data_A(Data_A), .Data_B(Data_B), .Flush(Flush), .Rd_En(Rd_En),
        .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Level(Level), .Empty(Empty),
        .Full(Full), .Threshold(Threshold), .Flag_Clear(Flag_Clear),
        .Overflow(Overflow), .Underflow(Underflow), .FIFO_IRQ(FIFO_IRQ)
    );

    always #5 SysClk = ~SysClk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of packed words plus the flag/tag bookkeeping
    logic [31:0] m_q[$];
    logic [3:0]  m_seq = '0;
    logic        m_ovf = 1'b0, m_udf = 1'b0, m_rvalid = 1'b0, m_sr = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          started = 1'b0;

    task automatic model_step();
        bit wr, rd_ok, wr_ok, e_ovf, e_udf;
        if (RST) begin
            m_q.delete();
            m_seq = '0; m_ovf = 0; m_udf = 0; m_rdata = '0; m_rvalid = 0;
            m_sr = Sample_Ready;
        end else begin
            wr = Enable && Sample_Ready && !m_sr;
            m_sr = Sample_Ready;
            e_ovf = 0; e_udf = 0;
            if (Flush) begin
                m_q.delete();
                m_seq = '0;
                m_rvalid = 0;
            end else begin
                rd_ok = Rd_En && (m_q.size() > 0);
                wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
                e_ovf = wr && !wr_ok;
                e_udf = Rd_En && (m_q.size() == 0);
                m_rvalid = rd_ok;
                if (rd_ok) m_rdata = m_q.pop_front();
                if (wr_ok) begin
                    m_q.push_back({m_seq, Data_B, 4'h0, Data_A});
                    m_seq = m_seq + 4'd1;
                end
            end
            if (Flag_Clear) begin m_ovf = 0; m_udf = 0; end
            if (e_ovf) m_ovf = 1;
            if (e_udf) m_udf = 1;
        end
    endtask

    initial forever begin
        @(posedge SysClk);
        model_step();
        started = 1'b1;
    end

    // Compare every output against the model on the falling edge
    initial forever begin
        @(negedge SysClk);
        if (started) begin
            int unsigned lvl;
            lvl = m_q.size();
            chk("rd_valid",  32'(Rd_Valid),  32'(m_rvalid));
            chk("rd_data",   Rd_Data,        m_rdata);
            chk("level",     32'(Level),     lvl);
            chk("empty",     32'(Empty),     32'(lvl == 0));
            chk("full",      32'(Full),      32'(lvl == DEPTH));
            chk("overflow",  32'(Overflow),  32'(m_ovf));
            chk("underflow", 32'(Underflow), 32'(m_udf));
            chk("irq",       32'(FIFO_IRQ),  32'((Threshold != 0) && (lvl >= 32'(Threshold))));
        end
    end

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] a, input logic [11:0] b);
        Data_A = a; Data_B = b; Sample_Ready = 1'b1;
        tick();
        Sample_Ready = 1'b0;
        tick();
    endtask

    task automatic rd();
        Rd_En = 1'b1;
        tick();
        Rd_En = 1'b0;
    endtask

    initial begin
        // Sample_Ready high through reset release must not be captured
        Enable = 1'b1; Sample_Ready = 1'b1; RST = 1'b1;
        tick(); tick();
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_rdata", Rd_Data, 32'h0);
        RST = 1'b0;
        tick(); tick(); tick();
        chk("sr_high_at_release", 32'(Level), 32'd0);
        Sample_Ready = 1'b0;
        tick();

        // Three samples, threshold IRQ, read back in order
        Threshold = 3'd3;
        pulse(12'h123, 12'hABC);
        pulse(12'h001, 12'hFFF);
        chk("irq_below", 32'(FIFO_IRQ), 32'd0);
        pulse(12'h800, 12'h000);
        chk("level3", 32'(Level), 32'd3);
        chk("irq_at_thr", 32'(FIFO_IRQ), 32'd1);
        rd();
        chk("word0_valid", 32'(Rd_Valid), 32'd1);
        chk("word0", Rd_Data, 32'h0ABC0123);
        chk("irq_after_read", 32'(FIFO_IRQ), 32'd0);
        rd();
        chk("word1", Rd_Data, 32'h1FFF0001);
        tick();
        chk("rd_valid_one_cycle", 32'(Rd_Valid), 32'd0);
        chk("rd_data_hold", Rd_Data, 32'h1FFF0001);
        rd();
        chk("word2", Rd_Data, 32'h20000800);
        chk("empty_after", 32'(Empty), 32'd1);

        // Long Sample_Ready high yields one write
        Sample_Ready = 1'b1;
        repeat (50) tick();
        Sample_Ready = 1'b0;
        tick();
        chk("long_high_one_write", 32'(Level), 32'd1);

        // Flush then overfill
        Flush = 1'b1; tick(); Flush = 1'b0;
        chk("flush_level", 32'(Level), 32'd0);
        for (int i = 0; i < 5; i++) pulse(12'(i), 12'(16 + i));
        chk("full_level", 32'(Level), 32'd4);
        chk("full_flag", 32'(Full), 32'd1);
        chk("overflow_set", 32'(Overflow), 32'd1);
        Flag_Clear = 1'b1; tick(); Flag_Clear = 1'b0;
        chk("overflow_clr", 32'(Overflow), 32'd0);

        // Full with simultaneous write and read
        Data_A = 12'h555; Data_B = 12'h666; Sample_Ready = 1'b1; Rd_En = 1'b1;
        tick();
        Sample_Ready = 1'b0; Rd_En = 1'b0;
        chk("wr_rd_full_word", Rd_Data, 32'h00100000);
        chk("wr_rd_full_level", 32'(Level), 32'd4);
        chk("wr_rd_full_noovf", 32'(Overflow), 32'd0);
        for (int i = 1; i < 4; i++) begin
            rd();
            chk("seq_order", 32'(Rd_Data[31:28]), 32'(i));
        end
        rd();
        chk("new_word_seq4", Rd_Data, 32'h46660555);

        // Underflow on empty read
        rd();
        chk("udf_valid", 32'(Rd_Valid), 32'd0);
        chk("udf_flag", 32'(Underflow), 32'd1);

        // Flush at level 2 resets the tag
        pulse(12'h010, 12'h020);
        pulse(12'h011, 12'h021);
        Flush = 1'b1; tick(); Flush = 1'b0;
        chk("flush2_level", 32'(Level), 32'd0);
        chk("flush_keeps_udf", 32'(Underflow), 32'd1);
        pulse(12'h0AA, 12'h0BB);
        rd();
        chk("seq_after_flush", Rd_Data, 32'h00BB00AA);

        // Threshold 0 disables IRQ
        Threshold = '0;
        for (int i = 0; i < 4; i++) pulse(12'(i), 12'(i));
        chk("thr0_noirq", 32'(FIFO_IRQ), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            Enable       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) Sample_Ready = ~Sample_Ready;
            Data_A       = 12'($urandom);
            Data_B       = 12'($urandom);
            Rd_En        = ($urandom_range(0, 9) < 4);
            Flush        = ($urandom_range(0, 49) == 0);
            Flag_Clear   = ($urandom_range(0, 19) == 0);
            RST          = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 63) == 0) Threshold = (AW+1)'($urandom_range(0, 7));
            tick();
        end
        RST = 1'b0; Flush = 1'b0; Flag_Clear = 1'b0; Rd_En = 1'b0;
        Sample_Ready = 1'b0; Enable = 1'b1; Threshold = 3'd1;
        tick();

        // Reset in the middle of a burst
        pulse(12'h321, 12'h654);
        pulse(12'h322, 12'h655);
        rd();
        rd();
        pulse(12'h323, 12'h656);
        Flag_Clear = 1'b0;
        Sample_Ready = 1'b1; Rd_En = 1'b1; RST = 1'b1;
        tick();
        Rd_En = 1'b0;
        chk("midrst_level", 32'(Level), 32'd0);
        chk("midrst_empty", 32'(Empty), 32'd1);
        chk("midrst_rdata", Rd_Data, 32'h0);
        chk("midrst_rvalid", 32'(Rd_Valid), 32'd0);
        chk("midrst_udf", 32'(Underflow), 32'd0);
        chk("midrst_irq", 32'(FIFO_IRQ), 32'd0);
        RST = 1'b0;
        tick(); tick();
        chk("midrst_no_capture", 32'(Level), 32'd0);
        Sample_Ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
